// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - shared defaults and state encoding for the VRAM write arbiter
package vram_arb_pkg;

    localparam int VRAM_ADDR_W    = 17;
    localparam int VRAM_DATA_W    = 16;
    localparam int VRAM_MAX_BURST = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin pick; a tie goes to whoever did not own last
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       valid,
    output logic       pick
);

    always_comb begin
        valid = |req;
        pick  = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_owner;
            default: pick = 1'b0;
        endcase
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// rtl/vram_write_arbiter.sv - single-port VRAM arbiter: display reads preempt, two burst writers share round-robin
module vram_write_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W    = VRAM_ADDR_W,
    parameter int DATA_W    = VRAM_DATA_W,
    parameter int MAX_BURST = VRAM_MAX_BURST
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                disp_rd_req,
    input  logic [ADDR_W-1:0]   disp_rd_addr,
    output logic [DATA_W-1:0]   disp_rd_data,
    output logic                disp_rd_valid,
    input  logic [1:0]          wr_req,
    input  logic [2*ADDR_W-1:0] wr_addr,
    input  logic [2*DATA_W-1:0] wr_data,
    input  logic [1:0]          wr_last,
    output logic [1:0]          wr_gnt,
    output logic [1:0]          wr_ack,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [1:0]       wr_gnt_q, wr_gnt_d;
    logic             disp_rd_valid_q, disp_rd_valid_d;

    logic             arb_valid;
    logic             arb_pick;
    logic             own_req;
    logic             own_last;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_data;
    logic             ack_any;
    logic [CNT_W-1:0] cnt_inc;
    logic             release_burst;

    rr_arbiter_2 u_rr (
        .req        (wr_req),
        .last_owner (last_owner_q),
        .valid      (arb_valid),
        .pick       (arb_pick)
    );

    assign own_req  = owner_q ? wr_req[1]  : wr_req[0];
    assign own_last = owner_q ? wr_last[1] : wr_last[0];
    assign own_addr = owner_q ? wr_addr[2*ADDR_W-1:ADDR_W] : wr_addr[ADDR_W-1:0];
    assign own_data = owner_q ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];
    assign cnt_inc  = burst_cnt_q + CNT_W'(1);

    // A display fetch always wins the port, so it stalls the owner's word without touching the burst.
    assign ack_any = !reset && (state_q == ST_BURST) && enable && own_req && !disp_rd_req;

    assign release_burst = (ack_any && (own_last || (cnt_inc == CNT_MAX))) || !own_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            owner_q         <= 1'b0;
            last_owner_q    <= 1'b1;
            burst_cnt_q     <= '0;
            wr_gnt_q        <= 2'b00;
            disp_rd_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_owner_q    <= last_owner_d;
            burst_cnt_q     <= burst_cnt_d;
            wr_gnt_q        <= wr_gnt_d;
            disp_rd_valid_q <= disp_rd_valid_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_owner_d    = last_owner_q;
        burst_cnt_d     = burst_cnt_q;
        wr_gnt_d        = wr_gnt_q;
        disp_rd_valid_d = disp_rd_req;
        case (state_q)
            ST_IDLE: begin
                if (enable && arb_valid) begin
                    state_d     = ST_BURST;
                    owner_d     = arb_pick;
                    wr_gnt_d    = onehot2(arb_pick);
                    burst_cnt_d = '0;
                end
            end
            ST_BURST: begin
                if (enable) begin
                    if (ack_any) begin
                        burst_cnt_d = cnt_inc;
                    end
                    // Leaving BURST always passes through one IDLE cycle before the next grant.
                    if (release_burst) begin
                        state_d      = ST_IDLE;
                        last_owner_d = owner_q;
                        wr_gnt_d     = 2'b00;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_ack    = 2'b00;
        if (disp_rd_req) begin
            mem_en   = 1'b1;
            mem_addr = disp_rd_addr;
        end else if (ack_any) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = own_addr;
            mem_wdata = own_data;
            wr_ack    = onehot2(owner_q);
        end
    end

    assign wr_gnt        = wr_gnt_q;
    assign busy          = (state_q == ST_BURST);
    assign disp_rd_valid = disp_rd_valid_q;
    assign disp_rd_data  = mem_rdata;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// tb/tb_vram_write_arbiter.sv - directed and randomized checks of vram_write_arbiter against a cycle model
module tb_vram_write_arbiter;

    localparam int AW = 17;
    localparam int DW = 16;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            disp_rd_req;
    logic [AW-1:0]   disp_rd_addr;
    logic [DW-1:0]   disp_rd_data;
    logic            disp_rd_valid;
    logic [1:0]      wr_req;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic [1:0]      wr_last;
    logic [1:0]      wr_gnt;
    logic [1:0]      wr_ack;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            busy;

    always #5 clk = ~clk;

    vram_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .disp_rd_req   (disp_rd_req),
        .disp_rd_addr  (disp_rd_addr),
        .disp_rd_data  (disp_rd_data),
        .disp_rd_valid (disp_rd_valid),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_last       (wr_last),
        .wr_gnt        (wr_gnt),
        .wr_ack        (wr_ack),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .busy          (busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who holds the port, which word of the burst, who went last.
    bit m_busy = 1'b0;
    bit m_owner = 1'b0;
    bit m_last = 1'b1;
    int m_cnt = 0;
    bit m_valid = 1'b0;

    // Write sources: each streams consecutive addresses and flags its final word.
    bit          s_act [2];
    int          s_left [2];
    logic [AW-1:0] s_addr [2];

    bit          t_reset;
    bit          t_en;
    bit          t_disp;
    logic [AW-1:0] t_daddr;
    logic [DW-1:0] t_rdata;
    int          ack_seen [2];

    function automatic logic [DW-1:0] pdata(input int i, input logic [AW-1:0] a);
        return a[DW-1:0] ^ ((i == 0) ? 16'h5A00 : 16'hC3C3);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input int i, input logic [AW-1:0] a, input int n);
        s_act[i]  = 1'b1;
        s_addr[i] = a;
        s_left[i] = n;
    endtask

    task automatic cycle();
        bit            exp_ack;
        bit            o;
        logic [1:0]    exp_gnt;
        bit            exp_en;
        bit            exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        int            new_cnt;
        reset        = t_reset;
        enable       = t_en;
        disp_rd_req  = t_disp;
        disp_rd_addr = t_daddr;
        mem_rdata    = t_rdata;
        for (int i = 0; i < 2; i++) begin
            wr_req[i]            = s_act[i];
            wr_addr[i*AW +: AW]  = s_addr[i];
            wr_data[i*DW +: DW]  = pdata(i, s_addr[i]);
            wr_last[i]           = s_act[i] && (s_left[i] == 1);
        end
        #1;
        o        = m_owner;
        exp_ack  = !t_reset && m_busy && t_en && s_act[o] && !t_disp;
        exp_gnt  = m_busy ? (o ? 2'b10 : 2'b01) : 2'b00;
        exp_en   = t_disp || exp_ack;
        exp_we   = !t_disp && exp_ack;
        exp_addr = t_disp ? t_daddr : (exp_ack ? s_addr[o] : '0);
        exp_wdata = (!t_disp && exp_ack) ? pdata(int'(o), s_addr[o]) : '0;
        check("wr_gnt", 32'(wr_gnt), 32'(exp_gnt));
        check("busy", 32'(busy), 32'(m_busy));
        check("disp_rd_valid", 32'(disp_rd_valid), 32'(m_valid));
        if (m_valid) check("disp_rd_data", 32'(disp_rd_data), 32'(t_rdata));
        check("wr_ack", 32'(wr_ack), exp_ack ? 32'(exp_gnt) : 32'd0);
        check("mem_en", 32'(mem_en), 32'(exp_en));
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
        if (wr_ack[0]) ack_seen[0]++;
        if (wr_ack[1]) ack_seen[1]++;
        @(posedge clk);
        if (t_reset) begin
            m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_cnt = 0; m_valid = 1'b0;
        end else begin
            m_valid = t_disp;
            if (!m_busy) begin
                if (t_en && (s_act[0] || s_act[1])) begin
                    m_owner = (s_act[0] && s_act[1]) ? !m_last : s_act[1];
                    m_busy  = 1'b1;
                    m_cnt   = 0;
                end
            end else if (t_en) begin
                new_cnt = exp_ack ? m_cnt + 1 : m_cnt;
                if ((exp_ack && (s_left[o] == 1 || new_cnt == MB)) || !s_act[o]) begin
                    m_busy = 1'b0;
                    m_last = o;
                end
                m_cnt = new_cnt;
            end
        end
        if (exp_ack) begin
            s_addr[o] = s_addr[o] + 1'b1;
            s_left[o] = s_left[o] - 1;
            if (s_left[o] == 0) s_act[o] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        s_act[0] = 1'b0; s_act[1] = 1'b0;
        t_reset = 1'b1; t_en = 1'b1; t_disp = 1'b0;
        run(2);
        t_reset = 1'b0;
        ack_seen[0] = 0; ack_seen[1] = 0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; disp_rd_req = 1'b0; disp_rd_addr = '0;
        wr_req = 2'b00; wr_addr = '0; wr_data = '0; wr_last = 2'b00; mem_rdata = '0;
        t_daddr = '0; t_rdata = 16'h1234;
        s_left[0] = 0; s_left[1] = 0; s_addr[0] = '0; s_addr[1] = '0;
        @(negedge clk);

        // single requester, three-word burst at 0x00010
        do_reset();
        start(0, 17'h00010, 3);
        run(6);
        check("r037_acks", 32'(ack_seen[0]), 32'd3);

        // simultaneous requests: 0 first, bubble, then 1
        do_reset();
        start(0, 17'h00100, 2);
        start(1, 17'h00200, 2);
        run(10);
        check("r038_acks0", 32'(ack_seen[0]), 32'd2);
        check("r038_acks1", 32'(ack_seen[1]), 32'd2);

        // forced release after MAX_BURST words, then the other requester
        do_reset();
        start(1, 17'h00300, 40);
        run(3);
        start(0, 17'h00400, 2);
        run(16);
        check("r039_acks1", 32'(ack_seen[1]), 32'd16);
        check("r039_acks0", 32'(ack_seen[0]), 32'd1);
        run(4);

        // display read collides with the second word
        do_reset();
        start(0, 17'h00500, 4);
        run(2);
        t_disp = 1'b1; t_daddr = 17'h1ABCD; t_rdata = 16'hBEEF;
        run(1);
        t_disp = 1'b0;
        run(6);
        check("r040_acks", 32'(ack_seen[0]), 32'd4);

        // enable low for five cycles mid-burst
        do_reset();
        start(1, 17'h00600, 6);
        run(3);
        t_en = 1'b0;
        run(5);
        check("r041_frozen", 32'(ack_seen[1]), 32'd2);
        t_en = 1'b1;
        run(8);
        check("r041_acks", 32'(ack_seen[1]), 32'd6);

        // reset in the middle of a burst
        do_reset();
        start(0, 17'h00700, 10);
        run(3);
        t_reset = 1'b1;
        run(1);
        t_reset = 1'b0;
        s_act[0] = 1'b0;
        run(3);

        // randomized traffic
        do_reset();
        for (int k = 0; k < 400; k++) begin
            t_reset = ($urandom % 100) == 0;
            t_en    = ($urandom % 8) != 0;
            t_disp  = ($urandom % 4) == 0;
            t_daddr = AW'($urandom);
            t_rdata = DW'($urandom);
            for (int i = 0; i < 2; i++) begin
                if (!s_act[i] && ($urandom % 6) == 0)
                    start(i, AW'($urandom), int'($urandom_range(1, 24)));
                else if (s_act[i] && ($urandom % 40) == 0)
                    s_act[i] = 1'b0;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vram_write_arbiter.md
VRAM_WRITE_ARBITER -- requirements
Module: vram_write_arbiter

Interface
REQ-001 Parameter ADDR_W, 17, video memory word-address width (240x320 = 76800 words).
REQ-002 Parameter DATA_W, 16, pixel word width (RGB565).
REQ-003 Parameter MAX_BURST, 16, maximum words per write grant before forced release.
REQ-004 clk  input  1  single clock; every register in the block SHALL be clocked on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  0 = grant and write-acknowledge activity frozen.
REQ-007 disp_rd_req  input  1  display pixel fetch request, absolute priority.
REQ-008 disp_rd_addr  input  ADDR_W  display fetch address.
REQ-009 disp_rd_data  output  DATA_W  fetched pixel.
REQ-010 disp_rd_valid  output  1  disp_rd_data valid.
REQ-011 wr_req  input  2  per-requester write request (bit 0 = SPI path, bit 1 = fill engine).
REQ-012 wr_addr  input  2*ADDR_W  per-requester write address, requester i in slice i.
REQ-013 wr_data  input  2*DATA_W  per-requester write data, requester i in slice i.
REQ-014 wr_last  input  2  marks final word of requester's burst.
REQ-015 wr_gnt  output  2  registered one-hot grant.
REQ-016 wr_ack  output  2  word accepted this cycle.
REQ-017 mem_en, mem_we  output  1 each  memory port enable and write enable.
REQ-018 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_rdata  input  DATA_W, 1-cycle read latency.
REQ-019 busy  output  1  high while state is BURST.

Function
REQ-020 States SHALL be IDLE and BURST, with registers owner (1 bit), last_owner (1 bit) and burst_cnt (clog2(MAX_BURST+1) bits).
REQ-021 disp_rd_req=1 SHALL drive mem_en=1, mem_we=0, mem_addr=disp_rd_addr combinationally in the same cycle, regardless of enable or state.
REQ-022 disp_rd_valid SHALL be disp_rd_req registered one cycle, and disp_rd_data SHALL equal mem_rdata in that cycle.
REQ-023 In IDLE with enable=1 and wr_req!=0, the block SHALL pick a requester: the single requester if only one; on a tie, the requester != last_owner.
REQ-024 It SHALL then enter BURST next cycle with owner set, wr_gnt=one-hot(owner) and burst_cnt=0.
REQ-025 wr_ack[owner] SHALL be 1 iff state=BURST, enable=1, wr_req[owner]=1 and disp_rd_req=0; wr_ack[~owner] SHALL always be 0.
REQ-026 On ack, the block SHALL drive mem_en=1, mem_we=1, mem_addr/mem_wdata from owner's slice, and increment burst_cnt.
REQ-027 BURST SHALL return to IDLE next cycle on any of: an acked word with wr_last=1; burst_cnt reaching MAX_BURST on an ack; wr_req[owner]=0 while enable=1.
REQ-028 On that return to IDLE, last_owner SHALL be set to owner and wr_gnt cleared; the IDLE cycle SHALL be a mandatory one-cycle arbitration bubble.
REQ-029 A display read colliding with an owner write SHALL stall the write (no ack) without releasing the grant or changing burst_cnt.
REQ-030 enable=0 SHALL hold state, owner, burst_cnt and wr_gnt, and SHALL suppress all acks and new grants.
REQ-031 When no access is issued, mem_en=0, mem_we=0, and mem_addr/mem_wdata SHALL be 0.
REQ-032 Grant latency SHALL be 1 cycle from wr_req sampled in IDLE to wr_gnt; ack SHALL be possible in the first BURST cycle.

Reset
REQ-033 Reset SHALL force state=IDLE, owner=0, last_owner=1, burst_cnt=0, wr_gnt=0, disp_rd_valid=0 and busy=0.
REQ-034 Reset during BURST SHALL abandon the burst; no ack SHALL occur in the reset cycle, and mem_en SHALL follow disp_rd_req only.

Structure
REQ-035 Shared package vram_arb_pkg SHALL hold ADDR_W, DATA_W, MAX_BURST defaults and the IDLE/BURST state encoding.
REQ-036 Tie-break logic SHALL be a sub-module rr_arbiter_2 (inputs req[1:0], last_owner; outputs valid, pick).

Verification
REQ-037 Reset, then wr_req=01, addr 0x00010, 3 words with last on the third -> wr_gnt=01 one cycle later, three consecutive acks writing 0x00010-0x00012, then IDLE, last_owner=0.
REQ-038 wr_req=11 simultaneous after reset -> requester 0 granted first; after its last-word ack, one IDLE cycle, then requester 1 granted.
REQ-039 Requester 1 holds wr_req for 40 words, no last -> forced release after 16 acks; with requester 0 requesting, requester 0 is granted next.
REQ-040 disp_rd_req pulsed during a burst at the 2nd word -> no ack that cycle, mem_we=0, mem_addr=disp_rd_addr, disp_rd_valid=1 next cycle with mem_rdata; the write resumes with burst_cnt unchanged.
REQ-041 enable=0 for 5 cycles mid-burst -> no acks, wr_gnt held; the burst completes normally after enable=1.
REQ-042 reset asserted mid-burst -> next cycle wr_gnt=00, busy=0, no ack in the reset cycle.
